// File: rtl/cram_wr_arb_pkg.sv
// Shared definitions for the palette CRAM write path: bus widths, FIFO entry
// layout and the arbiter state encoding.
package cram_wr_arb_pkg;

  localparam int CRAM_AW = 8;
  localparam int CRAM_DW = 15;
  localparam int ENTRY_W = CRAM_AW + CRAM_DW;
  localparam int BURST_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CPU  = 2'd1,
    ARB_DMA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [CRAM_AW-1:0] addr;
    logic [CRAM_DW-1:0] data;
  } cram_entry_t;

endpackage

// File: rtl/cram_wr_fifo.sv
// Small synchronous FIFO buffering Z80 palette writes as {addr,data} entries.
// Pushes while full are ignored; the owner is expected to pop only when non-empty.
module cram_wr_fifo
  import cram_wr_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = $clog2(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic               do_push, do_pop;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cram_wr_arb.sv
// Palette CRAM write-port arbiter: Z80 writes (via FIFO) versus the palette DMA
// loader, issued only on write slots and optionally only during blanking.
module cram_wr_arb
  import cram_wr_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DMA_BURST  = 8,
  parameter bit BLANK_ONLY = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slot,
  input  logic               blank,
  input  logic               cpu_we,
  input  logic [CRAM_AW-1:0] cpu_addr,
  input  logic [CRAM_DW-1:0] cpu_data,
  output logic               cpu_full,
  output logic               cpu_ovf,
  input  logic               dma_req,
  input  logic [CRAM_AW-1:0] dma_addr,
  input  logic [CRAM_DW-1:0] dma_data,
  output logic               dma_ack,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [CRAM_DW-1:0] cram_data,
  output logic               busy
);

  arb_state_e         state_q;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               cram_we_q, cpu_ovf_q;
  logic [CRAM_AW-1:0] cram_addr_q;
  logic [CRAM_DW-1:0] cram_data_q;

  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  cram_entry_t        head;
  logic               dma_req_eff, slot_ok, grant, pick_dma, grant_cpu, grant_dma;

  cram_wr_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (cpu_we),
    .wdata_i({cpu_addr, cpu_data}),
    .pop_i  (grant_cpu),
    .rdata_o(fifo_rdata),
    .full_o (cpu_full),
    .empty_o(fifo_empty)
  );

  assign head = fifo_rdata;

  // Masking with dma_ack stops the still-presented entry being written twice.
  assign dma_req_eff = dma_req && !dma_ack;
  assign slot_ok     = slot && (!BLANK_ONLY || blank);
  assign grant       = slot_ok && (!fifo_empty || dma_req_eff);
  assign pick_dma    = fifo_empty || (dma_req_eff && (burst_q < BURST_W'(DMA_BURST)));
  assign grant_cpu   = grant && !pick_dma;
  assign grant_dma   = grant && pick_dma;

  // Burst only counts DMA writes that actually held a CPU entry back.
  always_comb begin
    burst_d = burst_q;
    if (grant_cpu || !dma_req)
      burst_d = '0;
    else if (grant_dma && !fifo_empty && (burst_q < BURST_W'(DMA_BURST)))
      burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      burst_q     <= '0;
      cram_we_q   <= 1'b0;
      cpu_ovf_q   <= 1'b0;
      cram_addr_q <= '0;
      cram_data_q <= '0;
    end else begin
      burst_q   <= burst_d;
      cram_we_q <= grant;
      cpu_ovf_q <= cpu_we && cpu_full;
      if (grant_cpu) begin
        state_q     <= ARB_CPU;
        cram_addr_q <= head.addr;
        cram_data_q <= head.data;
      end else if (grant_dma) begin
        state_q     <= ARB_DMA;
        cram_addr_q <= dma_addr;
        cram_data_q <= dma_data;
      end
    end
  end

  assign cram_we   = cram_we_q;
  assign cram_addr = cram_addr_q;
  assign cram_data = cram_data_q;
  assign cpu_ovf   = cpu_ovf_q;
  assign dma_ack   = cram_we_q && (state_q == ARB_DMA);
  assign busy      = !fifo_empty || cram_we_q;

endmodule

// File: tb/tb_cram_wr_arb.sv
// Bench for cram_wr_arb: directed scenarios plus a randomized phase, all
// checked against a queue-based reference of the arbitration rules.
module tb_cram_wr_arb;

  localparam int DEPTH = 4;
  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slot = 1'b0, blank = 1'b1, cpu_we = 1'b0, dma_req = 1'b0;
  logic [7:0]  cpu_addr = '0, dma_addr = '0;
  logic [14:0] cpu_data = '0, dma_data = '0;

  logic        cpu_full, cpu_ovf, dma_ack, cram_we, busy;
  logic [7:0]  cram_addr;
  logic [14:0] cram_data;
  logic        cpu_full_b, cpu_ovf_b, dma_ack_b, cram_we_b, busy_b;
  logic [7:0]  cram_addr_b;
  logic [14:0] cram_data_b;

  cram_wr_arb #(.FIFO_DEPTH(DEPTH), .DMA_BURST(BURST), .BLANK_ONLY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .slot(slot), .blank(blank),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full), .cpu_ovf(cpu_ovf),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_data(cram_data), .busy(busy)
  );

  cram_wr_arb #(.FIFO_DEPTH(DEPTH), .DMA_BURST(BURST), .BLANK_ONLY(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .slot(slot), .blank(blank),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_full(cpu_full_b), .cpu_ovf(cpu_ovf_b),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_data(dma_data), .dma_ack(dma_ack_b),
    .cram_we(cram_we_b), .cram_addr(cram_addr_b), .cram_data(cram_data_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: pending CPU writes as a queue, DMA entries as a queue.
  logic [22:0] mq[$];
  int          m_burst;
  bit          m_we, m_ack, m_ovf;
  logic [7:0]  m_addr;
  logic [14:0] m_data;

  logic [22:0] dq[$];
  logic [23:0] wlog[$];
  logic [23:0] wlog_b[$];
  int          ovf_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    mq.delete();
    m_burst = 0; m_we = 0; m_ack = 0; m_ovf = 0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_step();
    int  n     = mq.size();
    bit  empty = (n == 0);
    bit  full  = (n == DEPTH);
    bit  req_e = dma_req && !m_ack;
    bit  g     = slot && (!empty || req_e);
    bit  gd    = g && (empty || (req_e && m_burst < BURST));
    bit  gc    = g && !gd;
    m_ovf = cpu_we && full;
    if (gc) {m_addr, m_data} = mq.pop_front();
    if (gd) begin m_addr = dma_addr; m_data = dma_data; end
    m_we  = g;
    m_ack = gd;
    if (gc || !dma_req) m_burst = 0;
    else if (gd && !empty && m_burst < BURST) m_burst++;
    if (cpu_we && !full) mq.push_back({cpu_addr, cpu_data});
  endfunction

  function automatic void dma_update();
    dma_req = (dq.size() > 0);
    if (dq.size() > 0) {dma_addr, dma_data} = dq[0];
  endfunction

  function automatic logic [23:0] log_at(input int i);
    logic [23:0] e = 24'hxxxxxx;
    if (i < wlog.size()) e = wlog[i];
    return e;
  endfunction

  task automatic compare_all();
    chk("cram_we",   cram_we,   m_we);
    chk("cram_addr", cram_addr, m_addr);
    chk("cram_data", cram_data, m_data);
    chk("dma_ack",   dma_ack,   m_ack);
    chk("cpu_ovf",   cpu_ovf,   m_ovf);
    chk("cpu_full",  cpu_full,  mq.size() == DEPTH);
    chk("busy",      busy,      (mq.size() != 0) || m_we);
  endtask

  task automatic step(input bit s, input bit we, input logic [7:0] a, input logic [14:0] d);
    slot = s; cpu_we = we; cpu_addr = a; cpu_data = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    if (cram_we)   wlog.push_back({dma_ack, cram_addr, cram_data});
    if (cram_we_b) wlog_b.push_back({dma_ack_b, cram_addr_b, cram_data_b});
    if (cpu_ovf)   ovf_cnt++;
    if (dma_ack) begin
      void'(dq.pop_front());
      dma_update();
    end
    slot = 0; cpu_we = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 15'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; slot = 0; cpu_we = 0;
    dq.delete(); dma_update();
    #1;
    chk("rst_we",   cram_we,   0);
    chk("rst_addr", cram_addr, 0);
    chk("rst_data", cram_data, 0);
    chk("rst_busy", busy,      0);
    chk("rst_full", cpu_full,  0);
    model_clear();
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_clear();
    ovf_cnt = 0;
    repeat (2) @(negedge clk);
    chk("init_we",   cram_we,   0);
    chk("init_ack",  dma_ack,   0);
    chk("init_ovf",  cpu_ovf,   0);
    chk("init_full", cpu_full,  0);
    chk("init_busy", busy,      0);
    chk("init_addr", cram_addr, 0);
    chk("init_data", cram_data, 0);
    rst_n = 1;

    // Single CPU write with blanking active.
    wlog.delete();
    step(0, 1, 8'h05, 15'h7FFF);
    for (int i = 0; i < 12; i++) step(i % 4 == 0, 0, 8'h00, 15'h0);
    chk("t1_nwr",  wlog.size(), 1);
    chk("t1_addr", log_at(0), {1'b0, 8'h05, 15'h7FFF});
    chk("t1_busy", busy, 0);

    // Overfill with no slots, then drain in order.
    wlog.delete(); ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h10 + 8'(i), 15'h100 + 15'(i));
      if (i == 3) chk("t2_full", cpu_full, 1);
    end
    idle(2);
    chk("t2_ovf_cnt", ovf_cnt, 1);
    for (int i = 0; i < 16; i++) step(i % 2 == 0, 0, 8'h00, 15'h0);
    chk("t2_nwr", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t2_order", log_at(i), {1'b0, 8'h10 + 8'(i), 15'h100 + 15'(i)});

    // DMA burst fairness with three queued CPU writes.
    wlog.delete();
    for (int i = 0; i < 3; i++) step(0, 1, 8'hA1 + 8'(i), 15'h2A1 + 15'(i));
    for (int i = 0; i < 16; i++) dq.push_back({8'(i), 15'h300 + 15'(i)});
    dma_update();
    for (int k = 0; k < 60; k++) step(k % 2 == 0, 0, 8'h00, 15'h0);
    chk("t3_nwr", wlog.size(), 19);
    begin
      logic [23:0] exp_seq[$];
      for (int i = 0; i < 8; i++) exp_seq.push_back({1'b1, 8'(i), 15'h300 + 15'(i)});
      exp_seq.push_back({1'b0, 8'hA1, 15'h2A1});
      for (int i = 8; i < 16; i++) exp_seq.push_back({1'b1, 8'(i), 15'h300 + 15'(i)});
      exp_seq.push_back({1'b0, 8'hA2, 15'h2A2});
      exp_seq.push_back({1'b0, 8'hA3, 15'h2A3});
      for (int i = 0; i < 19; i++) chk("t3_order", log_at(i), exp_seq[i]);
    end

    // Blank-only instance holds its write until blanking.
    do_reset();
    wlog_b.delete();
    blank = 0;
    step(0, 1, 8'hC4, 15'h1234);
    for (int i = 0; i < 100; i++) step(i % 4 == 1, 0, 8'h00, 15'h0);
    chk("t4_no_wr_b", wlog_b.size(), 0);
    chk("t4_busy_b",  busy_b, 1);
    blank = 1;
    step(1, 0, 8'h00, 15'h0);
    idle(1);
    chk("t4_nwr_b", wlog_b.size(), 1);
    if (wlog_b.size() > 0) chk("t4_wr_b", wlog_b[0][22:0], {8'hC4, 15'h1234});

    // Push while full coinciding with a CPU pop.
    wlog.delete();
    for (int i = 0; i < 4; i++) step(0, 1, 8'h50 + 8'(i), 15'h500 + 15'(i));
    chk("t5_full", cpu_full, 1);
    step(1, 1, 8'h5F, 15'h55F);
    chk("t5_ovf",    cpu_ovf,  1);
    chk("t5_nfull",  cpu_full, 0);
    for (int i = 0; i < 10; i++) step(i % 2 == 1, 0, 8'h00, 15'h0);
    chk("t5_nwr",  wlog.size(), 4);
    chk("t5_last", log_at(3), {1'b0, 8'h53, 15'h503});

    // Async reset while the FIFO holds entries and DMA is about to be granted.
    for (int i = 0; i < 3; i++) step(0, 1, 8'h60 + 8'(i), 15'h600 + 15'(i));
    dq.push_back({8'h70, 15'h700});
    dma_update();
    slot = 1;
    #2 rst_n = 0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_full", cpu_full, 0);
    chk("t6_we",   cram_we, 0);
    chk("t6_addr", cram_addr, 0);
    @(posedge clk); #1;
    chk("t6_we_held", cram_we, 0);
    chk("t6_ack_held", dma_ack, 0);
    @(negedge clk);
    rst_n = 1; slot = 0;
    model_clear();
    dq.delete(); dma_update();
    idle(2);
    chk("t6_empty", busy, 0);

    // Randomized traffic.
    begin
      int gap = 2;
      for (int k = 0; k < 600; k++) begin
        bit s;
        if (dq.size() == 0 && $urandom_range(0, 7) == 0) begin
          int n = $urandom_range(1, 12);
          for (int j = 0; j < n; j++) dq.push_back(23'($urandom));
          dma_update();
        end
        s = (gap >= 2) && ($urandom_range(0, 1) == 1);
        gap = s ? 1 : gap + 1;
        blank = 1'($urandom);
        step(s, $urandom_range(0, 2) == 0, 8'($urandom), 15'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
